// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth partial-product accumulator: adds one recoded group per cycle into a 64-bit sum.
// Optional BOOTH_ACC_EARLY_EXIT_EN finishes as soon as all remaining groups select zero.
module booth_pp_accumulator #(
    parameter int DATA_W     = 32,
    parameter int NUM_GROUPS = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     op1,
    input  logic                  s_or_us,
    input  logic [NUM_GROUPS-1:0] one,
    input  logic [NUM_GROUPS-1:0] two,
    input  logic [NUM_GROUPS-1:0] sign,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [2*DATA_W-1:0]   product,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int AW = DATA_W + 2;      // extended multiplicand
    localparam int PPW = DATA_W + 3;     // room for -2A
    localparam int PW = 2 * DATA_W;
    localparam int IW = $clog2(NUM_GROUPS);

`ifdef BOOTH_ACC_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         a_q, a_d;
    logic [NUM_GROUPS-1:0] one_q, one_d, two_q, two_d, sign_q, sign_d;
    logic [PW-1:0]         acc_q, acc_d, product_q, product_d;
    logic [IW-1:0]         idx_q, idx_d;

    logic [PPW-1:0]        pp_mag, pp;
    logic [PW-1:0]         pp_shifted, sum;
    logic [NUM_GROUPS-1:0] active, rest;
    logic                  last_group;

    always_comb begin
        if (one_q[idx_q]) begin
            pp_mag = {a_q[AW-1], a_q};
        end else if (two_q[idx_q]) begin
            pp_mag = {a_q, 1'b0};
        end else begin
            pp_mag = '0;
        end
        pp         = sign_q[idx_q] ? -pp_mag : pp_mag;
        pp_shifted = {{(PW-PPW){pp[PPW-1]}}, pp} << {idx_q, 1'b0};
        sum        = acc_q + pp_shifted;
        active     = one_q | two_q;
        // Groups strictly above the one being added this cycle.
        rest       = (active >> idx_q) >> 1;
        last_group = (idx_q == IW'(NUM_GROUPS - 1)) || (EarlyExit && (rest == '0));
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        one_d     = one_q;
        two_d     = two_q;
        sign_d    = sign_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        product_d = product_q;
        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_d    = s_or_us ? {{2{op1[DATA_W-1]}}, op1} : {2'b00, op1};
                        one_d  = one;
                        two_d  = two;
                        sign_d = sign;
                        acc_d  = '0;
                        idx_d  = '0;
                        if (EarlyExit && ((one | two) == '0)) begin
                            state_d   = StDone;
                            product_d = '0;
                        end else begin
                            state_d = StBusy;
                        end
                    end
                end
                StBusy: begin
                    acc_d = sum;
                    idx_d = idx_q + 1'b1;
                    if (last_group) begin
                        state_d   = StDone;
                        product_d = sum;
                        idx_d     = '0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            one_q     <= '0;
            two_q     <= '0;
            sign_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            one_q     <= one_d;
            two_q     <= two_d;
            sign_q    <= sign_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign product   = product_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator; latency expectations follow BOOTH_ACC_EARLY_EXIT_EN.
module tb_booth_pp_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op1 = '0;
    logic        s_or_us = 1'b0;
    logic [16:0] one = '0, two = '0, sign = '0;
    logic        in_valid = 1'b0, clear = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    booth_pp_accumulator #(.DATA_W(32), .NUM_GROUPS(17)) dut (
        .clk      (clk),
        .rst      (rst),
        .op1      (op1),
        .s_or_us  (s_or_us),
        .one      (one),
        .two      (two),
        .sign     (sign),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clear    (clear),
        .product  (product),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Golden radix-4 recoder: returns {sign, two, one}.
    function automatic logic [50:0] recode(input logic [31:0] y, input logic s);
        logic [34:0] ye;
        logic [2:0]  b;
        logic [16:0] o, t, g;
        ye = {(s ? {2{y[31]}} : 2'b00), y, 1'b0};
        for (int k = 0; k < 17; k++) begin
            b    = ye[2*k+2 -: 3];
            o[k] = b[1] ^ b[0];
            t[k] = (b == 3'b011) || (b == 3'b100);
            g[k] = b[2] & ~(b[1] & b[0]);
        end
        return {g, t, o};
    endfunction

    function automatic int exp_latency(input logic [16:0] o, input logic [16:0] t);
`ifdef BOOTH_ACC_EARLY_EXIT_EN
        int h = -1;
        for (int k = 0; k < 17; k++) if (o[k] | t[k]) h = k;
        return h + 1;
`else
        return 17;
`endif
    endfunction

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        if (s) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic start_raw(input string tag, input logic [31:0] a, input logic s,
                             input logic [16:0] o, input logic [16:0] t, input logic [16:0] g);
        check({tag, "_in_ready"}, in_ready, 1);
        op1 = a; s_or_us = s; one = o; two = t; sign = g; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Scramble inputs so the result depends on captured values only.
        op1 = 32'hDEADBEEF; s_or_us = ~s; one = ~o; two = ~t; sign = ~g;
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp_p, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_product"}, product, exp_p);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_product"}, product, exp_p);
    endtask

    task automatic run_raw(input string tag, input logic [31:0] a, input logic s,
                           input logic [16:0] o, input logic [16:0] t, input logic [16:0] g,
                           input logic [63:0] exp_p, input int exp_lat);
        start_raw(tag, a, s, o, t, g);
        finish_op(tag, exp_p, exp_lat);
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp_p);
        logic [50:0] r;
        r = recode(b, s);
        run_raw(tag, a, s, r[16:0], r[33:17], r[50:34], exp_p, exp_latency(r[16:0], r[33:17]));
    endtask

    task automatic watch_idle(input string tag);
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check(tag, 64'(seen), 0);
    endtask

    initial begin
        logic [50:0] r;
        logic [63:0] held;
`ifdef BOOTH_ACC_EARLY_EXIT_EN
        localparam int Lat5x3 = 2;
        localparam int LatZero = 0;
`else
        localparam int Lat5x3 = 17;
        localparam int LatZero = 17;
`endif
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        run_mul("u_ff_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
        run_raw("s_m1_m1", 32'hFFFFFFFF, 1'b1, 17'h1, 17'h0, 17'h1, 64'h1, exp_latency(17'h1, 0));
        run_mul("s_80_80", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
        run_mul("s_7f_80", 32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000);
        r = recode(32'd3, 1'b0);
        run_raw("u_5x3", 32'd5, 1'b0, r[16:0], r[33:17], r[50:34], 64'd15, Lat5x3);
        run_mul("u_zero", 32'd123, 32'd0, 1'b0, 64'd0);
        check("u_zero_lat_const", 64'(exp_latency(17'h0, 17'h0)), 64'(LatZero));
        // Group 0 one&two -> 1x; group 1 -2x; group 2 sign only -> -0.
        run_raw("raw_1x2x", 32'd7, 1'b0, 17'b001, 17'b011, 17'b110,
                64'hFFFFFFFFFFFFFFCF, exp_latency(17'b001, 17'b011));
        run_mul("s_m3_7", 32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFFFFFFFFEB);
        run_mul("u_mix", 32'h12345678, 32'h9ABCDEF0, 1'b0, mul_ref(32'h12345678, 32'h9ABCDEF0, 0));
        run_mul("s_mix", 32'h87654321, 32'h0FEDCBA9, 1'b1, mul_ref(32'h87654321, 32'h0FEDCBA9, 1));

        // Back-pressure in DONE with a competing request.
        r = recode(32'hFFFFFFFF, 1'b0);
        start_raw("stall", 32'hFFFFFFFF, 1'b0, r[16:0], r[33:17], r[50:34]);
        for (int i = 0; i < 17 && !out_valid; i++) tick();
        held = 64'hFFFFFFFE00000001;
        op1 = 32'd9; s_or_us = 1'b0; one = 17'h1; two = '0; sign = '0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_product", product, held);
            check("stall_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_release_in_ready", in_ready, 1);
        watch_idle("stall_no_queued_op");

        // Clear at group 8.
        r = recode(32'h0F0F0F0F, 1'b0);
        start_raw("clr", 32'hAAAA5555, 1'b0, r[16:0], r[33:17], r[50:34]);
        for (int i = 0; i < 8; i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_in_ready", in_ready, 1);
        check("clr_out_valid", out_valid, 0);
        check("clr_keeps_last", product, held);
        watch_idle("clr_no_valid");
        run_mul("after_clr", 32'd1000, 32'd1000, 1'b0, 64'd1000000);

        // Clear beats in_valid in IDLE.
        op1 = 32'd2; one = 17'h1; two = '0; sign = '0; in_valid = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        check("clr_prio_in_ready", in_ready, 1);
        watch_idle("clr_prio_no_valid");

        // Asynchronous reset at group 8.
        r = recode(32'h0F0F0F0F, 1'b1);
        start_raw("rstmid", 32'h13572468, 1'b1, r[16:0], r[33:17], r[50:34]);
        for (int i = 0; i < 8; i++) tick();
        #2 rst = 1'b1;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_product", product, 0);
        check("rstmid_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_release_in_ready", in_ready, 1);
        watch_idle("rstmid_no_valid");
        run_mul("after_rst", 32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFFFFFFFFFA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_pp_accumulator.md
BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, multiplicand/multiplier width; only 32 is supported.
REQ-002 SHALL have parameter NUM_GROUPS, default 17, number of radix-4 recoded groups (DATA_W/2+1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port op1  input  32  multiplicand.
REQ-006 SHALL have port s_or_us  input  1  1 = signed operands, 0 = unsigned.
REQ-007 SHALL have port one  input  17  per-group select-1x flag, group k at bit k.
REQ-008 SHALL have port two  input  17  per-group select-2x flag, group k at bit k.
REQ-009 SHALL have port sign  input  17  per-group negate flag, group k at bit k.
REQ-010 SHALL have port in_valid  input  1  operands and recoded groups valid.
REQ-011 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-012 SHALL have port clear  input  1  synchronous abort of any operation in progress.
REQ-013 SHALL have port product  output  64  accumulated product.
REQ-014 SHALL have port out_valid  output  1  product valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts product.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-018 SHALL, on in_valid&in_ready, capture op1, s_or_us, one, two and sign, clear the accumulator and group index to 0, and go to BUSY.
REQ-019 SHALL extend op1 to 34-bit A: sign-extended when s_or_us=1, zero-extended otherwise.
REQ-020 SHALL form partial product pp_k for group k as follows: one=1 gives A; two=1 gives 2A; neither gives 0; when sign=1, pp_k is negated in two's complement (-0 = 0).
REQ-021 SHALL, in BUSY, add pp_k sign-extended and shifted left by 2k into the 64-bit accumulator (modulo 2^64) once per cycle, in the order k = 0..16.
REQ-022 SHALL treat one=1 together with two=1 in the same group as 1x, and SHALL NOT assert any error for it.
REQ-023 SHALL go from BUSY to DONE on the cycle that group 16 is added, so that out_valid rises 17 cycles after the accept edge.
REQ-024 SHALL hold product and out_valid stable in DONE until out_ready=1, then go to IDLE on that edge.
REQ-025 SHALL keep product equal to the last completed result in IDLE; it is meaningful only while out_valid=1.
REQ-026 SHALL, when clear=1, go to IDLE from any state on the next edge, discarding the accumulator; clear takes priority over in_valid and out_ready.
REQ-027 SHALL ignore in_valid while in BUSY or DONE; no input is queued.

Reset
REQ-028 SHALL, on rst high, asynchronously force state to IDLE with product=0, accumulator=0, group index=0, out_valid=0 and in_ready=1 (in_ready held at 0 while rst is high).
REQ-029 SHALL abandon any operation in progress when reset is asserted mid-operation, and SHALL produce no out_valid for it after release.

Configuration
REQ-030 SHALL, when macro BOOTH_ACC_EARLY_EXIT_EN is defined, go to DONE as soon as every group from the current index through 16 has one=0 and two=0, including directly from the accept edge when all groups are zero.
REQ-031 SHALL, when BOOTH_ACC_EARLY_EXIT_EN is defined, produce the same product value as the full 17-cycle run.
REQ-032 SHALL, without BOOTH_ACC_EARLY_EXIT_EN, always spend exactly 17 BUSY cycles.

Verification
REQ-033 SHALL cover: unsigned 0xFFFFFFFF x 0xFFFFFFFF, groups from a golden recoder -> product 0xFFFFFFFE00000001, out_valid 17 cycles after accept.
REQ-034 SHALL cover: signed 0xFFFFFFFF x 0xFFFFFFFF (only group 0 has one=1, sign=1) -> product 0x0000000000000001.
REQ-035 SHALL cover: signed 0x80000000 x 0x80000000 -> product 0x4000000000000000; and 0x7FFFFFFF x 0x80000000 -> 0xC000000080000000.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0, and a new in_valid is ignored.
REQ-037 SHALL cover: clear or rst asserted at group 8 -> IDLE next edge (async for rst), no out_valid, and the next operation's result is correct.
REQ-038 SHALL cover: with BOOTH_ACC_EARLY_EXIT_EN, unsigned 5 x 3 -> product 15 with out_valid 2 cycles after accept; without the macro, 17 cycles.
